// File: rtl/uop_stim_gen.sv
// uop_stim_gen: issues num_uops micro-ops in LANES-wide bundles with CONST/INC/LFSR field modes.
// Define UOP_STIM_EXCEPT_EN to flag every EXC_PERIOD-th uop as an exception.
module uop_stim_gen #(
    parameter int          LANES         = 2,
    parameter int          NUM_UOPS      = 128,
    parameter int          XLEN          = 32,
    parameter int          ARCHFILE_SIZE = 16,
    parameter int          CNT_W         = 16,
    parameter int          EXC_PERIOD    = 16,
    parameter logic [31:0] LFSR_SEED     = 32'hACE10001,
    localparam int         UW            = $clog2(NUM_UOPS),
    localparam int         AW            = $clog2(ARCHFILE_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [CNT_W-1:0]      num_uops,
    input  logic                  accept,
    output logic                  uop_ready,
    output logic [LANES-1:0]      lane_valid,
    output logic [LANES*UW-1:0]   uop,
    output logic [LANES-1:0]      eoi,
    output logic [LANES*XLEN-1:0] imm,
    output logic [LANES-1:0]      use_imm,
    output logic [LANES*32-1:0]   pc,
    output logic [LANES-1:0]      except,
    output logic [LANES*AW-1:0]   src1_arch,
    output logic [LANES*AW-1:0]   src2_arch,
    output logic [LANES*AW-1:0]   dest_arch,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      issued
);
    localparam int CW = $clog2(LANES + 1);
`ifdef UOP_STIM_EXCEPT_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    state_t              st_q, st_d;
    logic [CNT_W-1:0]    num_q, num_d, issued_d;
    logic [1:0]          mode_q, mode_d;
    logic [31:0]         lfsr_q, lfsr_d;
    logic [31:0]         adv [LANES+1];
    logic [31:0]         lane_l [LANES];
    logic [CW-1:0]       cnt;
    logic [31:0]         n;
    logic                v, inc, lf;
    logic [LANES-1:0]    lv_d, eoi_d, use_d, exc_d;
    logic [LANES*UW-1:0] uop_d;
    logic [LANES*XLEN-1:0] imm_d;
    logic [LANES*32-1:0] pc_d;
    logic [LANES*AW-1:0] s1_d, s2_d, dst_d;

    always_comb begin
        st_d = st_q;
        num_d = num_q;
        mode_d = mode_q;
        issued_d = issued;
        lfsr_d = lfsr_q;
        cnt = CW'($countones(lane_valid));
        adv[0] = lfsr_q;
        for (int k = 1; k <= LANES; k++) adv[k] = lfsr_step(adv[k-1]);
        if (st_q == IDLE && start) begin
            st_d = num_uops != '0 ? RUN : DONE;
            num_d = num_uops;
            mode_d = mode;
            issued_d = '0;
        end else if (st_q == RUN && accept) begin
            issued_d = issued + CNT_W'(cnt);
            lfsr_d = adv[cnt];
            st_d = issued_d == num_q ? DONE : RUN;
        end else if (st_q == DONE) begin
            st_d = IDLE;
        end
        // Next bundle is built from next-state values so every output leaves a flop.
        inc = mode_d == 2'd1;
        lf = mode_d == 2'd2;
        n = '0;
        v = 1'b0;
        lane_l[0] = lfsr_d;
        for (int k = 1; k < LANES; k++) lane_l[k] = lfsr_step(lane_l[k-1]);
        lv_d = '0;
        eoi_d = '0;
        use_d = '0;
        exc_d = '0;
        uop_d = '0;
        imm_d = '0;
        pc_d = '0;
        s1_d = '0;
        s2_d = '0;
        dst_d = '0;
        for (int i = 0; i < LANES; i++) begin
            n = 32'(issued_d) + 32'(i);
            v = st_d == RUN && n < 32'(num_d);
            lv_d[i] = v;
            pc_d[i*32 +: 32] = v ? n << 2 : '0;
            uop_d[i*UW +: UW] = !v ? '0 : inc ? UW'(n) : lf ? lane_l[i][UW-1:0] : '0;
            dst_d[i*AW +: AW] = !v ? '0 : inc ? AW'(n) : lf ? lane_l[i][8 +: AW] : '0;
            s1_d[i*AW +: AW] = !v ? '0 : inc ? AW'(n - 32'd1) : lf ? lane_l[i][12 +: AW] : '0;
            s2_d[i*AW +: AW] = !v ? '0 : inc ? AW'(n - 32'd2) : lf ? lane_l[i][16 +: AW] : '0;
            imm_d[i*XLEN +: XLEN] = !v ? '0 : inc ? XLEN'(n) : lf ? XLEN'(lane_l[i]) : {(XLEN/4){n[1:0], 2'b00}};
            use_d[i] = v && (inc ? n[0] : lf ? lane_l[i][31] : 1'b1);
            eoi_d[i] = v && (inc ? n[0] : 1'b1);
            exc_d[i] = EXC_EN && v && ((n + 32'd1) % 32'(EXC_PERIOD) == 32'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= IDLE;
            num_q <= '0;
            mode_q <= '0;
            issued <= '0;
            lfsr_q <= LFSR_SEED;
            uop_ready <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            lane_valid <= '0;
            uop <= '0;
            eoi <= '0;
            imm <= '0;
            use_imm <= '0;
            pc <= '0;
            except <= '0;
            src1_arch <= '0;
            src2_arch <= '0;
            dest_arch <= '0;
        end else begin
            st_q <= st_d;
            num_q <= num_d;
            mode_q <= mode_d;
            issued <= issued_d;
            lfsr_q <= lfsr_d;
            uop_ready <= st_d == RUN;
            busy <= st_d == RUN;
            done <= st_d == DONE;
            lane_valid <= lv_d;
            uop <= uop_d;
            eoi <= eoi_d;
            imm <= imm_d;
            use_imm <= use_d;
            pc <= pc_d;
            except <= exc_d;
            src1_arch <= s1_d;
            src2_arch <= s2_d;
            dest_arch <= dst_d;
        end
    end
endmodule
